sisc_mem_arb: RTL and testbench

//  Arbiter/sequencer sharing the single-port SISC memory between the fetch

---
 rtl/sisc_mem_arb_if.sv | 41 ++++
 rtl/sisc_mem_arb.sv | 127 ++++++++++++
 tb/tb_sisc_mem_arb.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sisc_mem_arb_if.sv
// Bus bundle for sisc_mem_arb: the IF and DM requester ports plus the memory-side port.
// The arbiter uses the slave modport. The environment (requesters and memory) uses the master modport.
interface sisc_mem_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises *_req with its address/data and holds them until *_gnt.
  // *_gnt and *_valid are one-cycle pulses. A request dropped before *_gnt is withdrawn.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sisc_mem_arb.sv
// Shares the single-port SISC memory between fetch (IF) and load/store (DM) requesters.
// Default is DM priority with an IF starvation guard. Defining SISC_ARB_RR_EN selects round-robin instead.
module sisc_mem_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_f,
  sisc_mem_arb_if.slave         bus,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;    // 1 = DM holds or last held the memory
  logic             pick_dm;
  logic             any_req;

  assign any_req   = bus.if_req | bus.dm_req;
  assign dbg_state = state;

`ifdef SISC_ARB_RR_EN
  // On contention, grant the port that did not win last time.
  always_comb begin
    pick_dm = bus.dm_req;
    if (bus.dm_req && bus.if_req) pick_dm = ~owner;
  end
`else
  localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  logic [SC_W-1:0] starve_cnt;

  always_comb begin
    pick_dm = bus.dm_req;
    if (bus.if_req && starve_cnt == SC_W'(STARVE_MAX)) pick_dm = 1'b0;
  end

  // Counts DM wins taken while IF was waiting. It saturates, and any IF grant clears it.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!pick_dm)
        starve_cnt <= '0;
      else if (bus.if_req && starve_cnt != SC_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state         <= IDLE;
      cnt           <= '0;
      owner         <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_gnt    <= 1'b0;
      bus.dm_valid  <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            owner      <= pick_dm;
            cnt        <= CNT_W'(MEM_LAT - 1);
            bus.mem_en <= 1'b1;
            bus.busy   <= 1'b1;
            if (pick_dm) begin
              bus.dm_gnt    <= 1'b1;
              bus.mem_we    <= bus.dm_we;
              bus.mem_addr  <= bus.dm_addr;
              bus.mem_wdata <= bus.dm_wdata;
            end else begin
              bus.if_gnt   <= 1'b1;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= bus.if_addr;
            end
          end
        end
        ACCESS: begin
          bus.if_gnt <= 1'b0;
          bus.dm_gnt <= 1'b0;
          if (cnt == '0) begin
            // Read data is valid in the last cycle that mem_en is high.
            state      <= DONE;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            if (owner) begin
              bus.dm_valid <= 1'b1;
              if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
            end else begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.if_valid <= 1'b0;
          bus.dm_valid <= 1'b0;
          bus.busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Directed bench for sisc_mem_arb with MEM_LAT=2 and STARVE_MAX=4, driving a small behavioural memory.
module tb_sisc_mem_arb;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic       clk;
  logic       rst_f;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  sisc_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sisc_mem_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory. It preloads while in reset and writes on clock edges where mem_en and mem_we are high.
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (!rst_f) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'hCAFEF00D;
      mem[8'h20] <= 32'h0;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = bus.mem_en ? mem[bus.mem_addr[7:0]] : '0;

  // driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  int         n_g, cyc, first_cyc, last_cyc, both;
  int         c_ig, c_dg, c_iv, c_dv, c_en;
  logic [9:0] order;
  logic [9:0] exp_order;

  initial begin
    rst_f        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    step(); step(); step();

    check("rst_state",   32'(dbg_state), 32'd0);
    check("rst_mem_en",  32'(bus.mem_en), 32'd0);
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);

    // 1: IF-only read of 0x10
    rst_f       = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    step();
    check("t1_if_gnt",   32'(bus.if_gnt), 32'd1);
    check("t1_mem_en_a", 32'(bus.mem_en), 32'd1);
    check("t1_mem_we",   32'(bus.mem_we), 32'd0);
    check("t1_mem_addr", 32'(bus.mem_addr), 32'h10);
    check("t1_busy",     32'(bus.busy), 32'd1);
    bus.if_req = 1'b0;
    step();
    check("t1_gnt_pulse", 32'(bus.if_gnt), 32'd0);
    check("t1_mem_en_b",  32'(bus.mem_en), 32'd1);
    check("t1_valid_early", 32'(bus.if_valid), 32'd0);
    step();
    check("t1_if_valid", 32'(bus.if_valid), 32'd1);
    check("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    check("t1_mem_en_off", 32'(bus.mem_en), 32'd0);
    check("t1_busy_done", 32'(bus.busy), 32'd1);
    step();
    check("t1_valid_pulse", 32'(bus.if_valid), 32'd0);
    check("t1_busy_idle",  32'(bus.busy), 32'd0);
    check("t1_rdata_hold", bus.if_rdata, 32'hDEADBEEF);

    // 2: DM store then DM load at 0x20
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h0020;
    bus.dm_wdata = 32'h12345678;
    step();
    check("t2_st_gnt",   32'(bus.dm_gnt), 32'd1);
    check("t2_st_we",    32'(bus.mem_we), 32'd1);
    check("t2_st_addr",  32'(bus.mem_addr), 32'h20);
    check("t2_st_wdata", bus.mem_wdata, 32'h12345678);
    bus.dm_req = 1'b0;
    step();
    check("t2_st_we_b",  32'(bus.mem_we), 32'd1);
    step();
    check("t2_st_valid", 32'(bus.dm_valid), 32'd1);
    check("t2_st_rdata", bus.dm_rdata, 32'd0);
    check("t2_st_no_ifv", 32'(bus.if_valid), 32'd0);
    step();
    bus.dm_req = 1'b1;
    bus.dm_we  = 1'b0;
    step();
    check("t2_ld_gnt", 32'(bus.dm_gnt), 32'd1);
    check("t2_ld_we",  32'(bus.mem_we), 32'd0);
    bus.dm_req = 1'b0;
    step();
    step();
    check("t2_ld_valid", 32'(bus.dm_valid), 32'd1);
    check("t2_ld_rdata", bus.dm_rdata, 32'h12345678);
    step();

    // 3: both requesters held continuously
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 16'h0020;
    n_g = 0; cyc = 0; first_cyc = 0; last_cyc = 0; both = 0; order = '0;
    while (n_g < 10 && cyc < 200) begin
      step();
      cyc++;
      if (bus.if_gnt && bus.dm_gnt) both++;
      if (bus.if_gnt || bus.dm_gnt) begin
        if (n_g == 0) first_cyc = cyc;
        last_cyc = cyc;
        order[n_g] = bus.dm_gnt;
        n_g++;
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
`ifdef SISC_ARB_RR_EN
    exp_order = 10'b1010101010;  // last winner before this was DM, so IF goes first
`else
    exp_order = 10'b0111101111;  // DM x4, IF, DM x4, IF (bit 0 is the first grant)
`endif
    check("t3_grant_count", 32'(n_g), 32'd10);
    check("t3_grant_order", 32'(order), 32'(exp_order));
    check("t3_grant_span",  32'(last_cyc - first_cyc), 32'd36);
    check("t3_both_gnt",    32'(both), 32'd0);
    step(); step(); step();
    check("t3_idle", 32'(bus.busy), 32'd0);

    // 4: DM pulse during an IF access is ignored
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    c_ig = 0; c_dg = 0; c_iv = 0; c_dv = 0; c_en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        bus.if_req = 1'b0;
        bus.dm_req = 1'b1;
        bus.dm_we  = 1'b0;
      end
      if (i == 1) bus.dm_req = 1'b0;
      c_ig += int'(bus.if_gnt);
      c_dg += int'(bus.dm_gnt);
      c_iv += int'(bus.if_valid);
      c_dv += int'(bus.dm_valid);
      c_en += int'(bus.mem_en);
    end
    check("t4_if_gnts",   32'(c_ig), 32'd1);
    check("t4_dm_gnts",   32'(c_dg), 32'd0);
    check("t4_if_valids", 32'(c_iv), 32'd1);
    check("t4_dm_valids", 32'(c_dv), 32'd0);
    check("t4_en_cycles", 32'(c_en), 32'd2);

    // 5: reset in the middle of an access
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    step();
    check("t5_gnt", 32'(bus.if_gnt), 32'd1);
    bus.if_req = 1'b0;
    rst_f = 1'b0;
    #1;
    check("t5_rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("t5_rst_busy",   32'(bus.busy), 32'd0);
    check("t5_rst_gnt",    32'(bus.if_gnt), 32'd0);
    check("t5_rst_state",  32'(dbg_state), 32'd0);
    step();
    rst_f = 1'b1;
    c_iv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      c_iv += int'(bus.if_valid) + int'(bus.dm_valid);
    end
    check("t5_no_valid", 32'(c_iv), 32'd0);
    check("t5_rdata_cleared", bus.if_rdata, 32'd0);
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0030;
    step();
    check("t5_fresh_gnt", 32'(bus.if_gnt), 32'd1);
    bus.if_req = 1'b0;
    step();
    step();
    check("t5_fresh_valid", 32'(bus.if_valid), 32'd1);
    check("t5_fresh_rdata", bus.if_rdata, 32'hCAFEF00D);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
